// File: rtl/rf_buffer_burst_loader.sv
// Burst read engine for the RF array buffer: issues one word read per cycle under
// FIFO credit control and streams the returned words out with a last-word marker.
module rf_buffer_burst_loader #(
   parameter int unsigned ADDR_WIDTH = 10,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned LEN_WIDTH  = 8,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [LEN_WIDTH-1:0]  req_len,
   output logic                  buf_read,
   output logic [ADDR_WIDTH-1:0] buf_addr,
   input  logic [DATA_WIDTH-1:0] buf_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  out_last,
   output logic                  busy,
   output logic                  done
);

   localparam int unsigned PtrW = $clog2(FIFO_DEPTH);

   typedef enum logic [1:0] {StIdle, StIssue, StDrain, StDone} state_e;

   state_e                state_q, state_d;
   logic [ADDR_WIDTH-1:0] cur_addr_q, cur_addr_d;
   logic [ADDR_WIDTH-1:0] last_addr_q, last_addr_d;
   logic [LEN_WIDTH-1:0]  remaining_q, remaining_d;
   logic                  inflight_q, inflight_last_q;
   logic [PtrW-1:0]       wr_ptr_q, rd_ptr_q;
   logic [PtrW:0]         count_q;
   logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
   logic                  last_mem_q [FIFO_DEPTH];

   logic                  issue_last;
   logic                  push, pop;
   logic [PtrW+1:0]       occupancy;
   logic                  credit_ok;

   // Words already stored plus the one still in flight must fit in the FIFO.
   assign occupancy = {1'b0, count_q} + {{(PtrW + 1){1'b0}}, inflight_q};
   assign credit_ok = occupancy < (PtrW + 2)'(FIFO_DEPTH);

   assign push      = inflight_q;
   assign out_valid = (count_q != '0);
   assign pop       = out_valid && out_ready;
   assign out_data  = out_valid ? mem_q[rd_ptr_q] : '0;
   assign out_last  = out_valid ? last_mem_q[rd_ptr_q] : 1'b0;

   assign req_ready = (state_q == StIdle);
   assign busy      = (state_q != StIdle);
   assign done      = (state_q == StDone);
   assign buf_addr  = buf_read ? cur_addr_q : last_addr_q;
   assign issue_last = buf_read && (remaining_q == LEN_WIDTH'(1));

   always_comb begin
      state_d     = state_q;
      cur_addr_d  = cur_addr_q;
      last_addr_d = last_addr_q;
      remaining_d = remaining_q;
      buf_read    = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (req_valid) begin
               cur_addr_d  = req_addr;
               remaining_d = req_len;
               state_d     = (req_len == '0) ? StDone : StIssue;
            end
         end
         StIssue: begin
            if (credit_ok) begin
               buf_read    = 1'b1;
               last_addr_d = cur_addr_q;
               cur_addr_d  = cur_addr_q + 1'b1;
               remaining_d = remaining_q - 1'b1;
               if (remaining_q == LEN_WIDTH'(1)) state_d = StDrain;
            end
         end
         StDrain: begin
            // Finish on the handshake of the tagged word so done follows it directly.
            if (!inflight_q && pop && out_last) state_d = StDone;
         end
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q         <= StIdle;
         cur_addr_q      <= '0;
         last_addr_q     <= '0;
         remaining_q     <= '0;
         inflight_q      <= 1'b0;
         inflight_last_q <= 1'b0;
         wr_ptr_q        <= '0;
         rd_ptr_q        <= '0;
         count_q         <= '0;
      end else begin
         state_q         <= state_d;
         cur_addr_q      <= cur_addr_d;
         last_addr_q     <= last_addr_d;
         remaining_q     <= remaining_d;
         inflight_q      <= buf_read;
         inflight_last_q <= issue_last;
         if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         unique case ({push, pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push && !reset) begin
         mem_q[wr_ptr_q]      <= buf_data;
         last_mem_q[wr_ptr_q] <= inflight_last_q;
      end
   end

endmodule

// File: tb/tb_rf_buffer_burst_loader.sv
// Directed bench for rf_buffer_burst_loader with a one-cycle-latency buffer model
// returning {22'h0, addr}.
module tb_rf_buffer_burst_loader;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid;
   logic        req_ready;
   logic [9:0]  req_addr;
   logic [7:0]  req_len;
   logic        buf_read;
   logic [9:0]  buf_addr;
   logic [31:0] buf_data;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data;
   logic        out_last;
   logic        busy;
   logic        done;

   rf_buffer_burst_loader #(
      .ADDR_WIDTH(10),
      .DATA_WIDTH(32),
      .LEN_WIDTH (8),
      .FIFO_DEPTH(4)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .req_valid(req_valid),
      .req_ready(req_ready),
      .req_addr (req_addr),
      .req_len  (req_len),
      .buf_read (buf_read),
      .buf_addr (buf_addr),
      .buf_data (buf_data),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_data (out_data),
      .out_last (out_last),
      .busy     (busy),
      .done     (done)
   );

   always #5 clk = ~clk;

   always @(posedge clk) buf_data <= buf_read ? {22'h0, buf_addr} : 32'hDEAD_BEEF;

   int cyc = 0;
   always @(posedge clk) cyc++;

   int n_checks = 0;
   int n_fail   = 0;

   int rd_cnt, pop_cnt, done_cnt;
   int first_rd_cyc, last_rd_cyc, first_ov_cyc, last_hs_cyc, done_cyc;
   int acc_cyc, acc2_cyc;
   bit ovf;
   logic [9:0]  rd_addrs[$];
   logic [31:0] got_data[$];
   logic        got_last[$];

   always @(negedge clk) begin
      if (buf_read) begin
         if (rd_cnt == 0) first_rd_cyc = cyc;
         last_rd_cyc = cyc;
         rd_cnt++;
         rd_addrs.push_back(buf_addr);
      end
      if (out_valid && first_ov_cyc < 0) first_ov_cyc = cyc;
      if (out_valid && out_ready) begin
         got_data.push_back(out_data);
         got_last.push_back(out_last);
         pop_cnt++;
         if (out_last) last_hs_cyc = cyc;
      end
      if (done) begin
         done_cnt++;
         done_cyc = cyc;
      end
      if (rd_cnt - pop_cnt > 4) ovf = 1'b1;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic clear_mon();
      rd_cnt = 0; pop_cnt = 0; done_cnt = 0; ovf = 1'b0;
      first_rd_cyc = -1; last_rd_cyc = -1; first_ov_cyc = -1;
      last_hs_cyc = -1; done_cyc = -1;
      rd_addrs.delete(); got_data.delete(); got_last.delete();
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, " req_ready"}, req_ready, 1);
      check({tag, " buf_read"},  buf_read,  0);
      check({tag, " buf_addr"},  buf_addr,  0);
      check({tag, " out_valid"}, out_valid, 0);
      check({tag, " out_data"},  out_data,  0);
      check({tag, " out_last"},  out_last,  0);
      check({tag, " busy"},      busy,      0);
      check({tag, " done"},      done,      0);
   endtask

   task automatic request(input logic [9:0] addr, input logic [7:0] len);
      check("req_ready before request", req_ready, 1);
      req_addr  = addr;
      req_len   = len;
      req_valid = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0;
      acc_cyc   = cyc;
   endtask

   // mode 0: out_ready high; 1: toggle; 2: held low 20 cycles, then toggle
   task automatic wait_done(input int mode, input logic [31:0] exp_first);
      bit seen = 1'b0;
      for (int k = 0; k < 300; k++) begin
         if (done_cnt > 0) begin
            seen = 1'b1;
            break;
         end
         @(posedge clk); #1;
         if (mode == 2 && k == 19) begin
            check("backpressure read count", rd_cnt, 4);
            check("backpressure out_valid held", out_valid, 1);
            check("backpressure head word", out_data, exp_first);
         end
         case (mode)
            0:       out_ready = 1'b1;
            1:       out_ready = k[0];
            default: out_ready = (k >= 20) ? k[0] : 1'b0;
         endcase
      end
      if (!seen) begin
         n_checks++;
         n_fail++;
         $display("FAIL done timeout: got no done pulse expected one within 300 cycles");
      end
      out_ready = 1'b1;
      repeat (2) begin
         @(posedge clk); #1;
      end
   endtask

   task automatic check_burst(input logic [9:0] addr, input int len, input int mode,
                              input logic [31:0] exp_first, input logic [31:0] exp_last);
      logic [9:0] a;
      check("read count", rd_cnt, len);
      check("word count", got_data.size(), len);
      check("done pulses", done_cnt, 1);
      check("fifo overflow", ovf, 0);
      for (int i = 0; i < len; i++) begin
         a = addr + 10'(i);
         check("read addr", rd_addrs[i], a);
         check("out_data", got_data[i], {22'h0, a});
         check("out_last", got_last[i], (i == len - 1));
      end
      if (len == 0) begin
         check("zero-length done cycle", done_cyc, acc_cyc);
      end else begin
         check("first word", got_data[0], exp_first);
         check("last word", got_data[len-1], exp_last);
         check("first read latency", first_rd_cyc, acc_cyc);
         check("done after last handshake", done_cyc, last_hs_cyc + 1);
         if (mode == 0) begin
            check("consecutive reads", last_rd_cyc - first_rd_cyc + 1, len);
            check("first out_valid latency", first_ov_cyc, acc_cyc + 2);
         end
      end
   endtask

   typedef struct {
      logic [9:0]  addr;
      int          len;
      int          mode;
      logic [31:0] exp_first;
      logic [31:0] exp_last;
   } vec_t;

   vec_t vecs[5];

   initial begin
      vecs[0] = '{addr: 10'h010, len: 16, mode: 0, exp_first: 32'h010, exp_last: 32'h01F};
      vecs[1] = '{addr: 10'h3FE, len: 4,  mode: 0, exp_first: 32'h3FE, exp_last: 32'h001};
      vecs[2] = '{addr: 10'h100, len: 0,  mode: 0, exp_first: 32'h000, exp_last: 32'h000};
      vecs[3] = '{addr: 10'h040, len: 10, mode: 2, exp_first: 32'h040, exp_last: 32'h049};
      vecs[4] = '{addr: 10'h3FF, len: 1,  mode: 1, exp_first: 32'h3FF, exp_last: 32'h3FF};

      reset = 1'b1; req_valid = 1'b0; req_addr = '0; req_len = '0; out_ready = 1'b1;
      clear_mon();
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      check_reset_vals("reset");

      for (int v = 0; v < 5; v++) begin
         clear_mon();
         out_ready = (vecs[v].mode == 0);
         request(vecs[v].addr, 8'(vecs[v].len));
         wait_done(vecs[v].mode, vecs[v].exp_first);
         check_burst(vecs[v].addr, vecs[v].len, vecs[v].mode, vecs[v].exp_first,
                     vecs[v].exp_last);
      end

      // Second request held during a burst is taken only once back in IDLE.
      clear_mon();
      out_ready = 1'b1;
      request(10'h080, 8'd6);
      req_addr = 10'h200; req_len = 8'd2; req_valid = 1'b1;
      acc2_cyc = -1;
      for (int k = 0; k < 100; k++) begin
         @(posedge clk); #1;
         if (req_ready) begin
            acc2_cyc = cyc;
            break;
         end
      end
      check("busy burst words before accept", got_data.size(), 6);
      check("busy burst done", done_cnt, 1);
      check("held request accept cycle", acc2_cyc, last_hs_cyc + 2);
      @(posedge clk); #1;
      req_valid = 1'b0;
      acc_cyc = cyc;
      clear_mon();
      wait_done(0, 32'h200);
      check_burst(10'h200, 2, 0, 32'h200, 32'h201);

      // Reset after three words of an eight-word burst.
      clear_mon();
      out_ready = 1'b1;
      request(10'h000, 8'd8);
      for (int k = 0; k < 50; k++) begin
         @(posedge clk); #1;
         if (pop_cnt >= 3) break;
      end
      check("words before reset", pop_cnt, 3);
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      check_reset_vals("mid-burst reset");
      clear_mon();
      @(posedge clk); #1;
      check("returning word discarded", out_valid, 0);
      repeat (4) begin
         @(posedge clk); #1;
      end
      check("no done after reset", done_cnt, 0);
      check("no reads after reset", rd_cnt, 0);

      clear_mon();
      request(10'h005, 8'd2);
      wait_done(0, 32'h005);
      check_burst(10'h005, 2, 0, 32'h005, 32'h006);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/rf_buffer_burst_loader.md
# rf_buffer_burst_loader

Sequential read engine sitting directly upstream of `rf_array_buffer_interface`, driving its `risc_v_read`/`risc_v_addr` port and consuming `risc_v_data_out`. It accepts a burst request (start word address, word count) and issues one read per cycle to the RF array buffer. Returned words are staged in a small credit-controlled FIFO and presented on a valid/ready stream with a last-word marker. This replaces ad-hoc per-word loads such as 64 B line fetches (16 × 32-bit words).

## Interface

Parameters:
- `ADDR_WIDTH`, 10, buffer word-address width; must match the buffer instance.
- `DATA_WIDTH`, 32, word width.
- `LEN_WIDTH`, 8, burst-length field width, in words.
- `FIFO_DEPTH`, 4, output staging FIFO entries; power of two, ≥2.

Ports:
- `clk`  in  1  single clock; all logic is rising-edge.
- `reset`  in  1  synchronous, active-high.
- `req_valid`  in  1  burst request present.
- `req_ready`  out  1  high only in IDLE.
- `req_addr`  in  ADDR_WIDTH  start word address.
- `req_len`  in  LEN_WIDTH  words to fetch; 0 is legal.
- `buf_read`  out  1  to buffer `risc_v_read`.
- `buf_addr`  out  ADDR_WIDTH  to buffer `risc_v_addr`.
- `buf_data`  in  DATA_WIDTH  from buffer `risc_v_data_out`; valid exactly 1 cycle after `buf_read`.
- `out_valid`  out  1  stream word valid.
- `out_ready`  in  1  downstream accept.
- `out_data`  out  DATA_WIDTH  stream word.
- `out_last`  out  1  high with the final word of the burst.
- `busy`  out  1  high in any state other than IDLE.
- `done`  out  1  one-cycle pulse when the burst is complete.

## Operation

FSM states are IDLE, ISSUE, DRAIN and DONE.
- **IDLE:** `req_ready`=1. On `req_valid`, latch `req_addr` into `cur_addr` and `req_len` into `remaining`. If `req_len`==0, go to DONE; otherwise go to ISSUE.
- **ISSUE:** assert `buf_read` with `buf_addr`=`cur_addr` in every cycle where `fifo_count + inflight < FIFO_DEPTH`.
  - `inflight` is a 1-bit flag set when a read issues and cleared the next cycle.
  - Each issued read does `cur_addr <= cur_addr + 1`, wrapping modulo 2^ADDR_WIDTH (0x3FF → 0x000), and `remaining <= remaining − 1`.
  - Issuing the read with `remaining`==1 moves the FSM to DRAIN.
- **DRAIN:** no reads. Go to DONE when `inflight`==0, the FIFO is empty, and the last word has been accepted.
- **DONE:** `done`=1 for one cycle, then return to IDLE.
- **FIFO capture:** the cycle after any read, `buf_data` is pushed unconditionally. The credit check guarantees the FIFO is never full at push time.
- **FIFO output:** `out_valid` = FIFO not empty; `out_data` = head entry. The head pops on `out_valid && out_ready`. A simultaneous push and pop leaves the count unchanged.
- **`out_last`:** tagged at push time on the word whose read was issued with `remaining`==1; travels with that word through the FIFO.
- **Idle outputs:** `buf_addr` holds its last value when `buf_read`=0. Downstream must not rely on `buf_addr` when `buf_read` is low.
- **Requests while busy:** not accepted (`req_ready`=0); the requester must hold `req_valid`.

## Timing

- **Reset:** synchronous reset forces FSM=IDLE and clears the FIFO and `inflight`. Reset values:
  - `req_ready`=1
  - `buf_read`=0
  - `buf_addr`=0
  - `out_valid`=0
  - `out_data`=0
  - `out_last`=0
  - `busy`=0
  - `done`=0
- **Reset mid-burst:** aborts the burst with no `done` pulse. A word returning in the cycle after reset is discarded.
- **Request acceptance:** edge E0 with `req_valid && req_ready`. The first `buf_read` is high in the cycle following E0, and the first `out_valid` rises 2 cycles after E0.
- **Throughput:** with `out_ready` held high, one word per cycle. An N-word burst shows `buf_read` high for N consecutive cycles.
- **`done` timing:** `done` is high in the cycle after the `out_last` word handshake. The next request is accepted 2 cycles after that handshake at the earliest.
- **Zero-length request:** accepted at E0, `done` high in the cycle after E0, no `buf_read`.
- **Backpressure bound:** with `out_ready`=0, at most FIFO_DEPTH reads are issued, then `buf_read` stays low until a pop frees a credit.

## Test plan

The bench uses a buffer model that returns data = {22'h0, addr} one cycle after a read.

- **Basic burst:** `req_addr`=0x010, `req_len`=16, `out_ready`=1 → `buf_addr` 0x010..0x01F on 16 consecutive cycles. Output words 0x010..0x01F in order, `out_last` only on 0x01F, one `done` pulse.
- **Address wrap:** `req_addr`=0x3FE, `req_len`=4 → reads 0x3FE, 0x3FF, 0x000, 0x001; `out_data` matches.
- **Backpressure:** `req_len`=10 with `out_ready`=0 for 20 cycles → exactly 4 reads issued and `out_valid` held. Then toggle `out_ready` 1/0 → all 10 words delivered in order, none duplicated, FIFO never overflows.
- **Zero length and busy:** `req_len`=0 → `done` the cycle after acceptance, `buf_read` never high. A second `req_valid` during a burst is not accepted until IDLE.
- **Reset mid-burst:** assert `reset` after 3 of 8 words are delivered → the next cycle shows all reset values and no `done`. A new 2-word burst from 0x005 then completes correctly.
